// File: rtl/vedic_product_accumulator_pkg.sv
// vedic_product_accumulator_pkg: shared state type, default product width and count-width helper
package vedic_product_accumulator_pkg;
  typedef enum logic {ACCUM, HOLD} state_t;
  localparam int PROD_W_DEF = 16;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/vedic_product_accumulator_if.sv
// vedic_product_accumulator_if: product input and block-result output handshakes plus flush
interface vedic_product_accumulator_if
  import vedic_product_accumulator_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 4
);
  logic              clear;
  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] prod_data;
  logic              prod_last;
  logic              acc_valid;
  logic              acc_ready;
  logic [ACC_W-1:0]  acc_data;
  logic [CNT_W-1:0]  acc_count;
  logic              acc_ovf;
  modport master (
    output clear, prod_valid, prod_data, prod_last, acc_ready,
    input  prod_ready, acc_valid, acc_data, acc_count, acc_ovf
  );
  modport slave (
    input  clear, prod_valid, prod_data, prod_last, acc_ready,
    output prod_ready, acc_valid, acc_data, acc_count, acc_ovf
  );
endinterface

// File: rtl/vedic_product_accumulator_sat_add.sv
// vedic_product_accumulator_sat_add: combinational accumulator add with carry-out and optional saturation
module vedic_product_accumulator_sat_add #(
  parameter int ACC_W    = 24,
  parameter int PROD_W   = 16,
  parameter int SATURATE = 1
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [PROD_W-1:0] i_op,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_ovf
);
  logic [ACC_W:0] w_full;
  assign w_full = {1'b0, i_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, i_op};
  assign o_ovf  = w_full[ACC_W];
  // a saturated sum is all-ones, so any further nonzero add overflows again and it stays pinned
  assign o_sum  = (SATURATE != 0 && o_ovf) ? '1 : w_full[ACC_W-1:0];
endmodule

// File: rtl/vedic_product_accumulator.sv
// vedic_product_accumulator: sums product stream into blocks and presents each block sum over valid/ready
module vedic_product_accumulator
  import vedic_product_accumulator_pkg::*;
#(
  parameter int PROD_W    = PROD_W_DEF,
  parameter int ACC_W     = 24,
  parameter int BLOCK_LEN = 8,
  parameter int SATURATE  = 1
) (
  input logic                        clk,
  input logic                        rst,
  vedic_product_accumulator_if.slave bus
);
  localparam int CNT_W = cnt_w(BLOCK_LEN);
  state_t           r_state, w_state_nx;
  logic [ACC_W-1:0] r_sum, w_sum, r_acc_data;
  logic [CNT_W-1:0] r_count, w_count_nx, r_acc_count;
  logic             r_ovf, w_ovf, w_ovf_nx, r_acc_ovf;
  logic             w_accept, w_close, w_done;

  vedic_product_accumulator_sat_add #(
    .ACC_W(ACC_W), .PROD_W(PROD_W), .SATURATE(SATURATE)
  ) u_add (
    .i_acc(r_sum), .i_op(bus.prod_data), .o_sum(w_sum), .o_ovf(w_ovf)
  );

  assign w_accept   = (r_state == ACCUM) && bus.prod_valid;
  assign w_count_nx = r_count + 1'b1;
  assign w_ovf_nx   = r_ovf | w_ovf;
  // prod_last on the BLOCK_LEN-th product still closes only once
  assign w_close    = w_accept && (bus.prod_last || w_count_nx == CNT_W'(BLOCK_LEN));
  assign w_done     = (r_state == HOLD) && bus.acc_ready;

  // state register
  always_ff @(posedge clk)
    r_state <= rst ? ACCUM : w_state_nx;

  // next state: clear flushes from either state, dropping any pending result
  always_comb
    w_state_nx = bus.clear ? ACCUM : w_close ? HOLD : w_done ? ACCUM : r_state;

  // outputs decoded from state and the latched block result
  always_comb begin
    bus.prod_ready = (r_state == ACCUM);
    bus.acc_valid  = (r_state == HOLD);
    bus.acc_data   = r_acc_data;
    bus.acc_count  = r_acc_count;
    bus.acc_ovf    = r_acc_ovf;
  end

  // running sum/count/overflow and the result latched when a block closes
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      r_sum       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_acc_data  <= '0;
      r_acc_count <= '0;
      r_acc_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_sum   <= w_sum;
      r_count <= w_count_nx;
      r_ovf   <= w_ovf_nx;
      if (w_close) begin
        r_acc_data  <= w_sum;
        r_acc_count <= w_count_nx;
        r_acc_ovf   <= w_ovf_nx;
      end
    end else if (w_done) begin
      r_sum   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end
  end
endmodule
